// File: rtl/keypad_pkg.sv
// Shared constants for the keypad key FIFO: idle key code, register window addresses and the
// STATUS word bit layout.
package keypad_pkg;

    localparam logic [7:0] KEY_NONE    = 8'h00;

    localparam logic       ADDR_DATA   = 1'b0;
    localparam logic       ADDR_STATUS = 1'b1;

    localparam int unsigned ST_NOT_EMPTY = 0;
    localparam int unsigned ST_FULL      = 1;
    localparam int unsigned ST_OVF       = 2;
    localparam int unsigned ST_COUNT_LSB = 8;

endpackage

// File: rtl/keypad_sync_fifo.sv
// Single-clock FIFO holding key codes: storage, wrapping pointers, fill count and flags.
// Accepts a push while full only when a pop happens in the same cycle.
module keypad_sync_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned KEY_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [KEY_W-1:0]         wdata,
    output logic [KEY_W-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [KEY_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/keypad_key_fifo.sv
// Keypad consumer: turns new keypresses into FIFO pushes and exposes a DATA/STATUS read window.
// Define KEYPAD_KEY_FIFO_IRQ_EN to drive irq from the registered not-empty flag.
module keypad_key_fifo
    import keypad_pkg::*;
#(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned KEY_W  = 8,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [KEY_W-1:0]  key_code,
    input  logic              rd_en,
    input  logic              rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              irq
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [KEY_W-1:0]  key_prev_q;
    logic              ovf_q, ovf_d;
    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic [KEY_W-1:0]  head;
    logic [CW-1:0]     count;
    logic              full, empty;
    logic              press, pop, push;
    logic [DATA_W-1:0] status_word;

    assign press = (key_code != KEY_W'(KEY_NONE)) && (key_code != key_prev_q);
    assign pop   = rd_en && (rd_addr == ADDR_DATA) && !empty;
    assign push  = press && (!full || pop);

    keypad_sync_fifo #(
        .DEPTH (DEPTH),
        .KEY_W (KEY_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (key_code),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        status_word                          = '0;
        status_word[ST_NOT_EMPTY]            = !empty;
        status_word[ST_FULL]                 = full;
        status_word[ST_OVF]                  = ovf_q;
        status_word[ST_COUNT_LSB +: CW]      = count;
    end

    always_comb begin
        ovf_d     = ovf_q;
        rd_data_d = rd_data_q;
        if (rd_en) begin
            if (rd_addr == ADDR_STATUS) begin
                rd_data_d = status_word;
                ovf_d     = 1'b0;
            end else begin
                rd_data_d = empty ? '0 : {{(DATA_W-KEY_W){1'b0}}, head};
            end
        end
        // A drop in the same cycle as a STATUS read must not be lost.
        if (press && full && !pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            key_prev_q <= '0;
            ovf_q      <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            key_prev_q <= key_code;
            ovf_q      <= ovf_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

`ifdef KEYPAD_KEY_FIFO_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk) begin
        if (!rst_n) irq_q <= 1'b0;
        else        irq_q <= !empty;
    end

    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_key_fifo.sv
// Directed self-checking bench for keypad_key_fifo (DEPTH=8, KEY_W=8, DATA_W=32).
module tb_keypad_key_fifo;

    logic        clk;
    logic        rst_n;
    logic [7:0]  key_code;
    logic        rd_en;
    logic        rd_addr;
    logic [31:0] rd_data;
    logic        irq;

    int n_cmp;
    int n_fail;

    keypad_key_fifo #(
        .DEPTH  (8),
        .KEY_W  (8),
        .DATA_W (32)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_code (key_code),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .irq      (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic addr, output logic [31:0] d);
        rd_en   = 1'b1;
        rd_addr = addr;
        cyc();
        rd_en   = 1'b0;
        d       = rd_data;
    endtask

    task automatic press(input logic [7:0] k);
        key_code = k;
        cyc();
        key_code = 8'h00;
        cyc();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        do_reset();
        n_cmp++;
        if (rd_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rd_data: got %h want %h", rd_data, 32'h0);
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_irq: got %b want 0", irq);
        end
        do_read(1'b1, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_status: got %h want %h", d, 32'h0);
        end
        do_read(1'b0, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_empty_data: got %h want %h", d, 32'h0);
        end
    endtask

    task automatic test_held();
        logic [31:0] d;
        key_code = 8'h31;
        repeat (50) cyc();
        key_code = 8'h00;
        cyc();
        do_read(1'b1, d);
        n_cmp++;
        if (d !== 32'h0000_0101) begin
            n_fail++;
            $display("FAIL held_status: got %h want %h", d, 32'h0000_0101);
        end
        do_read(1'b0, d);
        n_cmp++;
        if (d !== 32'h0000_0031) begin
            n_fail++;
            $display("FAIL held_data: got %h want %h", d, 32'h0000_0031);
        end
        do_read(1'b1, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL held_status_after: got %h want %h", d, 32'h0);
        end
    endtask

    task automatic test_direct_change();
        logic [31:0] d;
        key_code = 8'h31;
        cyc();
        key_code = 8'h32;
        cyc();
        key_code = 8'h00;
        cyc();
        do_read(1'b1, d);
        n_cmp++;
        if (d !== 32'h0000_0201) begin
            n_fail++;
            $display("FAIL direct_status: got %h want %h", d, 32'h0000_0201);
        end
        do_read(1'b0, d);
        n_cmp++;
        if (d !== 32'h31) begin
            n_fail++;
            $display("FAIL direct_data0: got %h want %h", d, 32'h31);
        end
        do_read(1'b0, d);
        n_cmp++;
        if (d !== 32'h32) begin
            n_fail++;
            $display("FAIL direct_data1: got %h want %h", d, 32'h32);
        end
        do_read(1'b0, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL direct_empty_data: got %h want %h", d, 32'h0);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic [7:0]  k;
        for (int i = 0; i < 9; i++) begin
            k = 8'h41 + 8'(i);
            press(k);
        end
        do_read(1'b1, d);
        n_cmp++;
        if (d !== 32'h0000_0807) begin
            n_fail++;
            $display("FAIL ovf_status: got %h want %h", d, 32'h0000_0807);
        end
        do_read(1'b1, d);
        n_cmp++;
        if (d !== 32'h0000_0803) begin
            n_fail++;
            $display("FAIL ovf_status_cleared: got %h want %h", d, 32'h0000_0803);
        end
        for (int i = 0; i < 8; i++) begin
            do_read(1'b0, d);
            n_cmp++;
            if (d !== 32'h41 + 32'(i)) begin
                n_fail++;
                $display("FAIL ovf_data%0d: got %h want %h", i, d, 32'h41 + 32'(i));
            end
        end
        do_read(1'b1, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL ovf_drained_status: got %h want %h", d, 32'h0);
        end
    endtask

    task automatic test_full_pop_push();
        logic [31:0] d;
        logic [7:0]  k;
        for (int i = 0; i < 8; i++) begin
            k = 8'h51 + 8'(i);
            press(k);
        end
        key_code = 8'h59;
        rd_en    = 1'b1;
        rd_addr  = 1'b0;
        cyc();
        rd_en    = 1'b0;
        key_code = 8'h00;
        n_cmp++;
        if (rd_data !== 32'h51) begin
            n_fail++;
            $display("FAIL fullpop_data: got %h want %h", rd_data, 32'h51);
        end
        cyc();
        do_read(1'b1, d);
        n_cmp++;
        if (d !== 32'h0000_0803) begin
            n_fail++;
            $display("FAIL fullpop_status: got %h want %h", d, 32'h0000_0803);
        end
        for (int i = 0; i < 8; i++) begin
            do_read(1'b0, d);
            n_cmp++;
            if (d !== 32'h52 + 32'(i)) begin
                n_fail++;
                $display("FAIL fullpop_data%0d: got %h want %h", i, d, 32'h52 + 32'(i));
            end
        end
    endtask

    task automatic test_ovf_set_wins();
        logic [31:0] d;
        logic [7:0]  k;
        for (int i = 0; i < 8; i++) begin
            k = 8'h11 + 8'(i);
            press(k);
        end
        key_code = 8'h19;
        rd_en    = 1'b1;
        rd_addr  = 1'b1;
        cyc();
        rd_en    = 1'b0;
        key_code = 8'h00;
        n_cmp++;
        if (rd_data !== 32'h0000_0803) begin
            n_fail++;
            $display("FAIL setwins_pre: got %h want %h", rd_data, 32'h0000_0803);
        end
        cyc();
        do_read(1'b1, d);
        n_cmp++;
        if (d !== 32'h0000_0807) begin
            n_fail++;
            $display("FAIL setwins_ovf: got %h want %h", d, 32'h0000_0807);
        end
        for (int i = 0; i < 8; i++) do_read(1'b0, d);
        n_cmp++;
        if (d !== 32'h18) begin
            n_fail++;
            $display("FAIL setwins_last: got %h want %h", d, 32'h18);
        end
    endtask

    task automatic test_empty_press_read();
        logic [31:0] d;
        key_code = 8'h61;
        rd_en    = 1'b1;
        rd_addr  = 1'b0;
        cyc();
        rd_en    = 1'b0;
        key_code = 8'h00;
        n_cmp++;
        if (rd_data !== 32'h0) begin
            n_fail++;
            $display("FAIL nobypass_data: got %h want %h", rd_data, 32'h0);
        end
        do_read(1'b1, d);
        n_cmp++;
        if (d !== 32'h0000_0101) begin
            n_fail++;
            $display("FAIL nobypass_status: got %h want %h", d, 32'h0000_0101);
        end
        do_read(1'b0, d);
        n_cmp++;
        if (d !== 32'h61) begin
            n_fail++;
            $display("FAIL nobypass_queued: got %h want %h", d, 32'h61);
        end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        logic        exp_on;
`ifdef KEYPAD_KEY_FIFO_IRQ_EN
        exp_on = 1'b1;
`else
        exp_on = 1'b0;
`endif
        n_cmp++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_idle: got %b want 0", irq);
        end
        key_code = 8'h71;
        cyc();
        n_cmp++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_push_edge: got %b want 0", irq);
        end
        key_code = 8'h00;
        cyc();
        n_cmp++;
        if (irq !== exp_on) begin
            n_fail++;
            $display("FAIL irq_rise: got %b want %b", irq, exp_on);
        end
        do_read(1'b0, d);
        n_cmp++;
        if (irq !== exp_on) begin
            n_fail++;
            $display("FAIL irq_pop_edge: got %b want %b", irq, exp_on);
        end
        cyc();
        n_cmp++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL irq_fall: got %b want 0", irq);
        end
    endtask

    task automatic test_reset_mid_queue();
        logic [31:0] d;
        press(8'h21);
        press(8'h22);
        press(8'h23);
        do_reset();
        n_cmp++;
        if (irq !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_irq: got %b want 0", irq);
        end
        do_read(1'b1, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_status: got %h want %h", d, 32'h0);
        end
        do_read(1'b0, d);
        n_cmp++;
        if (d !== 32'h0) begin
            n_fail++;
            $display("FAIL midreset_data: got %h want %h", d, 32'h0);
        end
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        key_code = 8'h00;
        rd_en    = 1'b0;
        rd_addr  = 1'b0;
        test_reset();
        test_held();
        test_direct_change();
        test_overflow();
        test_full_pop_push();
        test_ovf_set_wins();
        test_empty_press_read();
        test_irq();
        test_reset_mid_queue();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
